mod_ifetch_ctrl: RTL
====================

// Module: mod_ifetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the MIPS core. Owns the word-addressed PC and drives the
//  combinational instruction ROM address every cycle. Buffers fetched words in a 2-entry queue.
//  Presents them to decode over a valid/ready handshake. Accepts branch/jump redirects and halt.
// PARAMETERS
//  ADDR_W    30     word-address width (byte PC[31:2]); rom_address and all PCs use this width
//  INSTR_W   32     instruction width
//  RESET_PC  0      word address of the first fetch after reset
//  QDEPTH    2      fetch-queue entries (fixed at 2; other values unsupported)
// PORTS
//  clk                 in   1        single clock, all state on rising edge
//  rst                 in   1        synchronous, active-high reset
//  rom_address         out  ADDR_W   word address to instruction ROM (= fetch_pc, combinational)
//  rom_instruction     in   INSTR_W  ROM data for rom_address, same cycle (combinational ROM)
//  redirect_valid      in   1        branch/jump taken this cycle
//  redirect_address    in   ADDR_W   target word address, sampled when redirect_valid=1
//  halt                in   1        level: stop issuing new fetches while high
//  if_valid            out  1        queue head valid for decode
//  if_ready            in   1        decode accepts head this cycle
//  if_instruction      out  INSTR_W  queue head instruction (0 when if_valid=0)
//  if_pc               out  ADDR_W   word address of queue head (0 when if_valid=0)
//  perf_fetch_cnt      out  32       [IFETCH_PERF_CNT_EN only] words pushed into queue
//  perf_stall_cnt      out  32       [IFETCH_PERF_CNT_EN only] cycles if_valid=1 && if_ready=0
// BEHAVIOUR
//  - Reset (rst=1 at edge): fetch_pc<=RESET_PC, queue emptied, state<=S_RUN.
//    Outputs next cycle: if_valid=0, if_instruction=0, if_pc=0, rom_address=RESET_PC.
//  - pop = if_valid & if_ready.
//  - push = (state==S_RUN) & ~halt & ~redirect_valid & (count<2 | pop).
//  - On push: enqueue {fetch_pc, rom_instruction}; fetch_pc<=fetch_pc+1 (mod 2^ADDR_W, 3FFFFFFF->0).
//  - Latency: the word at fetch_pc is visible on if_* the cycle after its push.
//    Throughput is 1 instruction/cycle with if_ready held high.
//  - Simultaneous push+pop on a full queue is allowed; count is unchanged.
//  - No push when full and no pop. fetch_pc and rom_address hold; if_* stays stable under backpressure.
//  - Redirect has highest priority, in any state:
//    - the head popped that cycle is consumed by decode;
//    - all other entries are flushed (count<=0); fetch_pc<=redirect_address; no push.
//    - if_valid=0 for exactly one cycle; the next valid head is redirect_address.
//  - FSM S_RUN / S_HALTED:
//    - S_RUN->S_HALTED when halt=1. Push is blocked the same cycle; the queue drains via normal pops.
//    - S_HALTED->S_RUN when halt=0; fetch resumes at the held fetch_pc.
//    - In S_HALTED a redirect updates fetch_pc and flushes; the state stays S_HALTED.
//  - rst during any state or full queue overrides everything, including redirect.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined: perf_fetch_cnt and perf_stall_cnt ports exist.
//    Counters are 32-bit, cleared by rst, increment on push / stall cycle, wrap at 2^32.
//  Not defined: ports and counters are absent; fetch behaviour is identical.
// STRUCTURE
//  Shared package mips_pkg:
//    ADDR_W, INSTR_W, RESET_PC default, INSTR_NOP=32'h0, ifetch_state_t {S_RUN, S_HALTED}.
//  Sub-module mod_ifetch_queue:
//    2-entry {pc, instr} FIFO with push/pop/flush, count and head outputs.
//  The controller holds fetch_pc, the FSM, push/pop/redirect arbitration and the optional counters.
// TESTING (bench ROM: word i returns 32'hA000_0000+i)
//  1. rst 2 cycles then release, if_ready=1:
//     first valid cycle shows if_pc=0, instr A0000000; then 1, 2, 3... one per cycle, no gaps.
//  2. if_ready=0 for 5 cycles after the first valid:
//     count reaches 2, rom_address holds 2, if_instruction stays A0000000.
//     On release, pcs 0,1,2,3 appear with no duplicate or skip.
//  3. Queue full (pcs 4,5), redirect to 0x10 with if_ready=0:
//     next cycle if_valid=0; following cycle if_pc=0x10, A0000010; pcs 4/5 never reappear.
//  4. Assert halt at pc 7 with if_ready=1:
//     queued words drain, if_valid falls, rom_address frozen.
//     Deassert after 4 cycles: the next pc follows the last pushed one.
//  5. Redirect to 30'h3FFFFFFF: successive if_pc 3FFFFFFF, 00000000, 00000001.
//  6. rst for one cycle with a full queue and redirect_valid=1:
//     next cycle if_valid=0, rom_address=RESET_PC; with macro, both counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
// Contents:
//   ADDR_W, INSTR_W - default word-address and instruction widths
//   RESET_PC        - default word address of the first fetch after reset
//   INSTR_NOP       - value shown on the decode bus when no instruction is valid
//   ifetch_state_t  - fetch sequencer states (S_RUN, S_HALTED)
package mips_pkg;

    localparam int          ADDR_W    = 30;
    localparam int          INSTR_W   = 32;
    localparam logic [29:0] RESET_PC  = 30'd0;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_HALTED  = 1'b1
    } ifetch_state_t;

endpackage

// File: rtl/mod_ifetch_queue.sv
// Two-entry {pc, instruction} fetch queue. Entry 0 is always the head, so a
// pop shifts entry 1 down. Flush empties the queue and wins over push/pop.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   push, push_pc/instr    - enqueue one word (caller guarantees room)
//   pop                    - discard the head (caller guarantees it is valid)
//   flush                  - drop every entry
//   count                  - number of valid entries (0..2)
//   head_valid/pc/instr    - queue head; pc/instr read 0 when empty
module mod_ifetch_queue
    import mips_pkg::INSTR_NOP;
#(
    parameter int ADDR_W  = 30,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [ADDR_W-1:0]  pc0_r, pc1_r, pc0_s, pc1_s;
    logic [INSTR_W-1:0] in0_r, in1_r, in0_s, in1_s;
    logic [1:0]         count_r, count_s;

    // Next-state of the two entries and the occupancy count.
    always_comb begin
        pc0_s   = pc0_r;
        pc1_s   = pc1_r;
        in0_s   = in0_r;
        in1_s   = in1_r;
        count_s = count_r;
        if (flush) begin
            count_s = 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_r == 2'd2) begin
                        pc0_s = pc1_r;
                        in0_s = in1_r;
                        pc1_s = push_pc;
                        in1_s = push_instr;
                    end else begin
                        pc0_s = push_pc;
                        in0_s = push_instr;
                    end
                end
                2'b01: begin
                    pc0_s   = pc1_r;
                    in0_s   = in1_r;
                    count_s = count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        pc0_s = push_pc;
                        in0_s = push_instr;
                    end else begin
                        pc1_s = push_pc;
                        in1_s = push_instr;
                    end
                    count_s = count_r + 2'd1;
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end
    end

    // Entry and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc0_r   <= '0;
            pc1_r   <= '0;
            in0_r   <= '0;
            in1_r   <= '0;
            count_r <= 2'd0;
        end else begin
            pc0_r   <= pc0_s;
            pc1_r   <= pc1_s;
            in0_r   <= in0_s;
            in1_r   <= in1_s;
            count_r <= count_s;
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != 2'd0);
    assign head_pc    = head_valid ? pc0_r : {ADDR_W{1'b0}};
    assign head_instr = head_valid ? in0_r : INSTR_W'(INSTR_NOP);

endmodule

// File: rtl/mod_ifetch_ctrl.sv
// Instruction-fetch sequencer. Holds the word-addressed fetch PC, drives the
// combinational instruction ROM, buffers fetched words in a 2-entry queue and
// presents them to decode over a valid/ready handshake. Redirects flush the
// queue and retarget fetch; halt stops new fetches while the queue drains.
// Optional feature macro: IFETCH_PERF_CNT_EN adds perf_fetch_cnt (words
// pushed) and perf_stall_cnt (cycles with if_valid=1 and if_ready=0).
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   rom_address / rom_instruction     - ROM address (= fetch pc) and its data
//   redirect_valid / redirect_address - taken branch/jump and its target
//   halt                              - level, blocks new fetches while high
//   if_valid/if_ready/if_instruction/if_pc - decode handshake and head word
//   perf_fetch_cnt, perf_stall_cnt    - performance counters (macro only)
module mod_ifetch_ctrl
    import mips_pkg::ifetch_state_t;
    import mips_pkg::S_RUN;
    import mips_pkg::S_HALTED;
#(
    parameter int                ADDR_W   = 30,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 30'd0,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [INSTR_W-1:0] rom_instruction,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_address,
    input  logic               halt,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instruction,
    output logic [ADDR_W-1:0]  if_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    ifetch_state_t     state_r, state_s;
    logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_s;
    logic [1:0]        count_s;
    logic              pop_s, push_s;

    assign pop_s  = if_valid & if_ready;
    // Redirect blocks the push so the stale word at fetch_pc never enters the queue.
    assign push_s = (state_r == S_RUN) & ~halt & ~redirect_valid
                  & ((count_s < 2'(QDEPTH)) | pop_s);

    mod_ifetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_pc    (fetch_pc_r),
        .push_instr (rom_instruction),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .count      (count_s),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_instr (if_instruction)
    );

    // Next fetch pc: redirect beats sequential advance; otherwise hold.
    always_comb begin
        fetch_pc_s = fetch_pc_r;
        if (redirect_valid) begin
            fetch_pc_s = redirect_address;
        end else if (push_s) begin
            fetch_pc_s = fetch_pc_r + ADDR_W'(1);
        end else begin
            fetch_pc_s = fetch_pc_r;
        end
    end

    // Run/halt next-state; a redirect never changes the state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_RUN: begin
                if (halt) begin
                    state_s = S_HALTED;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_HALTED: begin
                if (!halt) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_HALTED;
                end
            end
            default: begin
                state_s = S_RUN;
            end
        endcase
    end

    // State and fetch pc registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_RUN;
            fetch_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
        end
    end

    assign rom_address = fetch_pc_r;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_r, stall_cnt_r;

    // Free-running wrap-around counters of pushes and decode stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            fetch_cnt_r <= fetch_cnt_r + {31'd0, push_s};
            stall_cnt_r <= stall_cnt_r + {31'd0, (if_valid & ~if_ready)};
        end
    end

    assign perf_fetch_cnt = fetch_cnt_r;
    assign perf_stall_cnt = stall_cnt_r;
`else
    // No performance counters in this build.
`endif

endmodule
